// File: rtl/alu_seq16.sv
// alu_seq16: sequences 16-bit ADD/SUB/INC/DEC through an external 8-bit ALU in two passes.
// It drives the low byte first, then the high byte; the high pass uses ADC/SBC so the ALU consumes the low-pass carry.
// Latency: o_done pulses 3 edges after the accepting edge (2 for INC16/DEC16 with no low carry when GB80_SEQ16_SHORTCUT_EN is defined).
// Backpressure: i_start is accepted only in IDLE and ignored while o_busy is high; there is no output stall.
// Ports: i_clk/i_rst (async, active-high); i_start/i_op/i_opa/i_opb/i_flags_in form the request;
//        o_alu_a/o_alu_b/o_alu_ctrl drive the ALU; i_alu_data/i_alu_flags are its combinational result;
//        o_busy/o_done/o_result/o_flags report status and the registered result.
// Optional macro: GB80_SEQ16_SHORTCUT_EN skips the high pass of INC16/DEC16 when the low pass gives no carry or borrow.
module alu_seq16 #(
  parameter int DATA_WIDTH   = 8,  // only 8 is supported
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [1:0]              i_op,
  input  logic [2*DATA_WIDTH-1:0] i_opa,
  input  logic [2*DATA_WIDTH-1:0] i_opb,
  input  logic [7:0]              i_flags_in,
  output logic [DATA_WIDTH-1:0]   o_alu_a,
  output logic [DATA_WIDTH-1:0]   o_alu_b,
  output logic [OPCODE_WIDTH-1:0] o_alu_ctrl,
  input  logic [DATA_WIDTH-1:0]   i_alu_data,
  input  logic [7:0]              i_alu_flags,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2*DATA_WIDTH-1:0] o_result,
  output logic [7:0]              o_flags
);

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_SUB16 = 2'b01;

  localparam logic [OPCODE_WIDTH-1:0] CTRL_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] CTRL_ADC = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] CTRL_SUB = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] CTRL_SBC = OPCODE_WIDTH'(3);

  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [2*DATA_WIDTH-1:0] opa_q, opa_d;
  logic [2*DATA_WIDTH-1:0] opb_q, opb_d;
  logic [3:0]              fin_q, fin_d;     // Z,N,H,C of the incoming F register
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;       // low result byte from the first pass
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [7:0]              flags_q, flags_d;

  logic is_sub;   // SUB16 / DEC16
  logic is_step;  // INC16 / DEC16: second operand is the constant 1
  logic hi_h, hi_c;

  // Only H and C of the ALU flags matter here; Z is recomputed over all 16 bits.
  logic unused_alu_flags;
  assign unused_alu_flags = ^{i_alu_flags[7:6], i_alu_flags[3:0]};

  // The opcode encoding splits cleanly: bit 0 selects subtract, bit 1 selects +/-1.
  assign is_sub  = op_q[0];
  assign is_step = op_q[1];
  assign hi_h    = i_alu_flags[FLAG_H];
  assign hi_c    = i_alu_flags[FLAG_C];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    fin_d      = fin_q;
    lo_d       = lo_q;
    result_d   = result_q;
    flags_d    = flags_q;
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LO;
          op_d    = i_op;
          opa_d   = i_opa;
          opb_d   = i_opb;
          fin_d   = i_flags_in[7:4];
        end
      end

      S_LO: begin
        o_alu_a    = opa_q[DATA_WIDTH-1:0];
        o_alu_b    = is_step ? DATA_WIDTH'(1) : opb_q[DATA_WIDTH-1:0];
        o_alu_ctrl = is_sub ? CTRL_SUB : CTRL_ADD;
        lo_d       = i_alu_data;
        state_d    = S_HI;
`ifdef GB80_SEQ16_SHORTCUT_EN
        // No carry/borrow out of the low byte: the high byte passes through unchanged.
        if (is_step && !hi_c) begin
          state_d  = S_DONE;
          result_d = {opa_q[2*DATA_WIDTH-1:DATA_WIDTH], i_alu_data};
          flags_d  = {fin_q, 4'b0000};
        end
`endif
      end

      S_HI: begin
        // The ALU's own flag path supplies the carry recorded at the end of the low pass.
        o_alu_a    = opa_q[2*DATA_WIDTH-1:DATA_WIDTH];
        o_alu_b    = is_step ? '0 : opb_q[2*DATA_WIDTH-1:DATA_WIDTH];
        o_alu_ctrl = is_sub ? CTRL_SBC : CTRL_ADC;
        state_d    = S_DONE;
        result_d   = {i_alu_data, lo_q};
        case (op_q)
          // ADD16 leaves Z as it was in F; SUB16 computes Z over the full 16 bits.
          OP_ADD16: flags_d = {fin_q[3], 1'b0, hi_h, hi_c, 4'b0000};
          OP_SUB16: flags_d = {(i_alu_data == '0) && (lo_q == '0), 1'b1, hi_h, hi_c, 4'b0000};
          default:  flags_d = {fin_q, 4'b0000};
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      fin_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      fin_q    <= fin_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: models the 8-bit ALU (including its carry flag register),
// predicts each 16-bit result from whole-word arithmetic and scores completions from a queue.
module tb_alu_seq16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [15:0] i_opa, i_opb;
  logic [7:0]  i_flags_in;
  logic [7:0]  o_alu_a, o_alu_b;
  logic [2:0]  o_alu_ctrl;
  logic [7:0]  alu_data, alu_flags;
  logic        o_busy, o_done;
  logic [15:0] o_result;
  logic [7:0]  o_flags;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  flg;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq16 #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_op(i_op),
    .i_opa(i_opa), .i_opb(i_opb), .i_flags_in(i_flags_in),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
    .i_alu_data(alu_data), .i_alu_flags(alu_flags),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_flags(o_flags)
  );

  // 8-bit ALU model: ADD/ADC/SUB/SBC; ADC/SBC take carry from its own flag register.
  logic       alu_c_q = 1'b0;
  logic       cin;
  logic [8:0] s9;
  logic [4:0] h5;
  always_comb begin
    cin       = 1'b0;
    s9        = '0;
    h5        = '0;
    alu_data  = '0;
    alu_flags = '0;
    if (o_alu_ctrl == 3'd1 || o_alu_ctrl == 3'd3) cin = alu_c_q;
    case (o_alu_ctrl)
      3'd0, 3'd1: begin
        s9 = {1'b0, o_alu_a} + {1'b0, o_alu_b} + {8'd0, cin};
        h5 = {1'b0, o_alu_a[3:0]} + {1'b0, o_alu_b[3:0]} + {4'd0, cin};
        alu_data  = s9[7:0];
        alu_flags = {s9[7:0] == 8'h00, 1'b0, h5[4], s9[8], 4'b0000};
      end
      3'd2, 3'd3: begin
        s9 = {1'b0, o_alu_a} - {1'b0, o_alu_b} - {8'd0, cin};
        h5 = {1'b0, o_alu_a[3:0]} - {1'b0, o_alu_b[3:0]} - {4'd0, cin};
        alu_data  = s9[7:0];
        alu_flags = {s9[7:0] == 8'h00, 1'b1, h5[4], s9[8], 4'b0000};
      end
      default: ;
    endcase
  end
  always @(posedge clk) alu_c_q <= alu_flags[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: whole 16-bit arithmetic, H from bit 11 carry/borrow.
  task automatic ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, output logic [15:0] r, output logic [7:0] fl,
                        output int lat);
    logic [16:0] s;
    logic [12:0] h;
    s   = '0;
    h   = '0;
    lat = 3;
    case (op)
      2'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        h  = {1'b0, a[11:0]} + {1'b0, b[11:0]};
        r  = s[15:0];
        fl = {f[7], 1'b0, h[12], s[16], 4'b0000};
      end
      2'd1: begin
        s  = {1'b0, a} - {1'b0, b};
        h  = {1'b0, a[11:0]} - {1'b0, b[11:0]};
        r  = s[15:0];
        fl = {s[15:0] == 16'h0000, 1'b1, h[12], s[16], 4'b0000};
      end
      2'd2: begin
        r  = a + 16'd1;
        fl = {f[7:4], 4'b0000};
`ifdef GB80_SEQ16_SHORTCUT_EN
        if (a[7:0] != 8'hFF) lat = 2;
`endif
      end
      default: begin
        r  = a - 16'd1;
        fl = {f[7:4], 4'b0000};
`ifdef GB80_SEQ16_SHORTCUT_EN
        if (a[7:0] != 8'h00) lat = 2;
`endif
      end
    endcase
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", o_result, mon_e.res);
        check("flags", o_flags, mon_e.flg);
        check("latency", cyc - mon_e.c0, mon_e.lat);
      end
    end
  end

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 10 && o_busy; k++) @(negedge clk);
    check(tag, o_busy, 0);
  endtask

  // glitch=1 keeps i_start high with different operands during LO/HI.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, input bit glitch);
    logic [15:0] r;
    logic [7:0]  fl;
    int          lat;
    bit          sub, step;
    ref_op(op, a, b, f, r, fl, lat);
    sub  = op[0];
    step = op[1];
    @(negedge clk);
    i_op = op; i_opa = a; i_opb = b; i_flags_in = f; i_start = 1'b1;
    sb_q.push_back('{r, fl, lat, cyc});
    @(negedge clk);
    i_start = glitch;
    if (glitch) begin
      i_op = ~op; i_opa = ~a; i_opb = ~b; i_flags_in = ~f;
    end
    check("lo_a", o_alu_a, a[7:0]);
    check("lo_b", o_alu_b, step ? 8'h01 : b[7:0]);
    check("lo_ctrl", o_alu_ctrl, sub ? 3'd2 : 3'd0);
    if (lat == 3) begin
      @(negedge clk);
      check("hi_a", o_alu_a, a[15:8]);
      check("hi_b", o_alu_b, step ? 8'h00 : b[15:8]);
      check("hi_ctrl", o_alu_ctrl, sub ? 3'd3 : 3'd1);
    end
    i_start = 1'b0;
    wait_idle("idle_timeout");
    check("hold_result", o_result, r);
    check("idle_drive", {o_alu_a, o_alu_b, o_alu_ctrl}, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [7:0]  rf;
    rst = 1'b1; i_start = 1'b0; i_op = '0; i_opa = '0; i_opb = '0; i_flags_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_result", o_result, 0);
    check("rst_flags", o_flags, 0);
    check("rst_drive", {o_alu_a, o_alu_b, o_alu_ctrl}, 0);
    rst = 1'b0;

    run_op(2'd0, 16'h1234, 16'h0FCC, 8'h00, 1'b0);  // 2200, H=1
    run_op(2'd0, 16'h1234, 16'h0FCC, 8'h80, 1'b0);  // Z carried from F
    run_op(2'd1, 16'h1000, 16'h1000, 8'h00, 1'b0);  // 0000, C0
    run_op(2'd1, 16'h1000, 16'h0001, 8'hF0, 1'b0);  // 0FFF, H borrow
    run_op(2'd1, 16'h0001, 16'h0002, 8'h00, 1'b0);  // FFFF, C borrow
    run_op(2'd2, 16'hFFFF, 16'h5555, 8'hB0, 1'b0);  // wrap to 0000
    run_op(2'd3, 16'h0000, 16'h0000, 8'h50, 1'b0);  // wrap to FFFF
    run_op(2'd2, 16'h12FE, 16'h0000, 8'h10, 1'b0);  // no low carry
    run_op(2'd3, 16'h1234, 16'hFFFF, 8'h00, 1'b0);
    run_op(2'd0, 16'h00FF, 16'h0001, 8'h10, 1'b1);  // start ignored in LO/HI
    run_op(2'd1, 16'h2000, 16'h0FFF, 8'h00, 1'b1);
    run_op(2'd2, 16'h0010, 16'h0000, 8'h70, 1'b1);

    // Abort in HI: nothing is queued, so any o_done here is reported as spurious.
    @(negedge clk);
    i_op = 2'd0; i_opa = 16'h1234; i_opb = 16'h0FCC; i_flags_in = 8'h00; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    check("abort_in_hi", o_alu_ctrl, 3'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_result", o_result, 0);
    check("abort_flags", o_flags, 0);
    check("abort_drive", {o_alu_a, o_alu_b, o_alu_ctrl}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_quiet", o_busy, 0);
    run_op(2'd0, 16'h8000, 16'h8000, 8'h00, 1'b0);  // 0000, C=1

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 8'($urandom) & 8'hF0;
      run_op(2'($urandom_range(0, 3)), ra, rb, rf, 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
